// File: rtl/strobe_decoder.sv
// strobe_decoder: registered one-hot decoder with handshaked timed strobes and an autonomous scan mode
module strobe_decoder #(
  parameter int SEL_W  = 3,
  parameter int HOLD_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [HOLD_W-1:0]       hold,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic                    busy,
  output logic                    scan_wrap
);
  localparam int OUT_W = 1 << SEL_W;
  typedef enum logic [1:0] {IDLE, STROBE, SCAN} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] idx, idx_n;
  logic [HOLD_W-1:0] cnt, cnt_n, load;
  logic [OUT_W-1:0] out_n;
  logic wrap_n;
  assign in_ready = (state == IDLE) && en && !mode && rst_n;
  assign load = (hold == '0) ? '0 : hold - HOLD_W'(1);
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    out_n = out;
    wrap_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n = STROBE;
          out_n = OUT_W'(1) << in_sel;
          cnt_n = load;
        end else if (en && mode) begin
          state_n = SCAN;
          idx_n = '0;
          out_n = OUT_W'(1);
          cnt_n = load;
        end else begin
          out_n = '0;
        end
      end
      STROBE: begin
        if (!en || cnt == '0) begin
          state_n = IDLE;
          out_n = '0;
          cnt_n = '0;
        end else begin
          cnt_n = cnt - HOLD_W'(1);
        end
      end
      SCAN: begin
        if (!en || !mode) begin
          state_n = IDLE;
          out_n = '0;
          cnt_n = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - HOLD_W'(1);
        end else begin
          idx_n = idx + SEL_W'(1);
          out_n = OUT_W'(1) << idx_n;
          cnt_n = load;
          wrap_n = &idx;
        end
      end
      default: begin
        state_n = IDLE;
        out_n = '0;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      out <= '0;
      busy <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      out <= out_n;
      busy <= state_n != IDLE;
      scan_wrap <= wrap_n;
    end
  end
endmodule
